// File: rtl/axil_timer.sv
// AXI4-Lite 64-bit free-running timer with compare-match level interrupt.
// Define AXIL_TIMER_PRESCALER_EN to add a 16-bit tick prescaler register at 0x18.
module axil_timer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [63:0] CNT_RESET  = 64'h0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        irq_o
);
  localparam int unsigned OW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  typedef enum logic [2:0] {
    SEL_CTRL, SEL_STATUS, SEL_CNT_LO, SEL_CNT_HI,
    SEL_CMP_LO, SEL_CMP_HI, SEL_PRESC, SEL_NONE
  } sel_e;

  function automatic sel_e decode(input logic [OW-1:0] off);
    case (32'(off))
      32'd0:   decode = SEL_CTRL;
      32'd1:   decode = SEL_STATUS;
      32'd2:   decode = SEL_CNT_LO;
      32'd3:   decode = SEL_CNT_HI;
      32'd4:   decode = SEL_CMP_LO;
      32'd5:   decode = SEL_CMP_HI;
`ifdef AXIL_TIMER_PRESCALER_EN
      32'd6:   decode = SEL_PRESC;
`endif
      default: decode = SEL_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    merge = old;
    for (int unsigned i = 0; i < 4; i++)
      if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[31:ADDR_WIDTH], awaddr[1:0],
                         araddr[31:ADDR_WIDTH], araddr[1:0]};

  wstate_e w_state, w_next;
  rstate_e r_state, r_next;
  logic [OW-1:0] aw_off_q, wr_off;
  logic [31:0]   wdata_q, wr_data, rd_val, hi_shadow;
  logic [3:0]    wstrb_q, wr_strb;
  logic          aw_hs, w_hs, ar_hs, commit, rd_err, tick, hw_match;
  sel_e          wr_sel, rd_sel;
  logic [2:0]    ctrl;
  logic          status_match;
  logic [63:0]   cnt, cmp;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) w_state <= W_IDLE;
    else       w_state <= w_next;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:    if (aw_hs && w_hs) w_next = W_RESP;
                 else if (aw_hs)    w_next = W_HAVE_AW;
                 else if (w_hs)     w_next = W_HAVE_W;
      W_HAVE_AW: if (w_hs)   w_next = W_RESP;
      W_HAVE_W:  if (aw_hs)  w_next = W_RESP;
      W_RESP:    if (bready) w_next = W_IDLE;
      default:   w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    wready  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    bvalid  = (w_state == W_RESP);
  end

  // The completing half comes straight from the bus so the write commits on its own handshake edge.
  assign commit  = (w_state != W_RESP) && (w_next == W_RESP);
  assign wr_off  = (w_state == W_HAVE_AW) ? aw_off_q : awaddr[ADDR_WIDTH-1:2];
  assign wr_data = (w_state == W_HAVE_W) ? wdata_q : wdata;
  assign wr_strb = (w_state == W_HAVE_W) ? wstrb_q : wstrb;
  assign wr_sel  = decode(wr_off);

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      aw_off_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp    <= 2'b00;
    end else begin
      if (aw_hs)  aw_off_q <= awaddr[ADDR_WIDTH-1:2];
      if (w_hs)   begin wdata_q <= wdata; wstrb_q <= wstrb; end
      if (commit) bresp <= (wr_sel == SEL_NONE) ? 2'b10 : 2'b00;
    end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) r_state <= R_IDLE;
    else       r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_DATA;
      R_DATA:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
  end

`ifdef AXIL_TIMER_PRESCALER_EN
  logic [15:0] presc, div;
  assign tick = (div == presc);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      presc <= '0;
      div   <= '0;
    end else if (commit && wr_sel == SEL_PRESC) begin
      if (wr_strb[0]) presc[7:0]  <= wr_data[7:0];
      if (wr_strb[1]) presc[15:8] <= wr_data[15:8];
      div <= '0;
    end else begin
      div <= tick ? '0 : div + 16'd1;
    end
`else
  assign tick = 1'b1;
`endif

  assign rd_sel = decode(araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_sel)
      SEL_CTRL:   rd_val = {29'h0, ctrl};
      SEL_STATUS: rd_val = {31'h0, status_match};
      SEL_CNT_LO: rd_val = cnt[31:0];
      SEL_CNT_HI: rd_val = hi_shadow;
      SEL_CMP_LO: rd_val = cmp[31:0];
      SEL_CMP_HI: rd_val = cmp[63:32];
`ifdef AXIL_TIMER_PRESCALER_EN
      SEL_PRESC:  rd_val = {16'h0, presc};
`endif
      default:    rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      rdata     <= '0;
      rresp     <= 2'b00;
      hi_shadow <= '0;
    end else if (ar_hs) begin
      rdata <= rd_val;
      rresp <= rd_err ? 2'b10 : 2'b00;
      if (rd_sel == SEL_CNT_LO) hi_shadow <= cnt[63:32];
    end

  assign hw_match = ctrl[0] && (cnt == cmp);

  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      ctrl         <= '0;
      status_match <= 1'b0;
      cnt          <= CNT_RESET;
      cmp          <= '1;
      irq_o        <= 1'b0;
    end else begin
      irq_o <= status_match & ctrl[1];
      // Hardware set wins over a same-cycle W1C.
      status_match <= hw_match | (status_match &
                      ~(commit && wr_sel == SEL_STATUS && wr_strb[0] && wr_data[0]));
      if (commit && wr_sel == SEL_CTRL && wr_strb[0]) ctrl <= wr_data[2:0];
      if (commit && wr_sel == SEL_CMP_LO) cmp[31:0]  <= merge(cmp[31:0], wr_data, wr_strb);
      if (commit && wr_sel == SEL_CMP_HI) cmp[63:32] <= merge(cmp[63:32], wr_data, wr_strb);
      if (commit && wr_sel == SEL_CNT_LO)
        cnt[31:0] <= merge(cnt[31:0], wr_data, wr_strb);
      else if (commit && wr_sel == SEL_CNT_HI)
        cnt[63:32] <= merge(cnt[63:32], wr_data, wr_strb);
      else if (ctrl[0] && tick)
        cnt <= (hw_match && ctrl[2]) ? '0 : cnt + 64'd1;
    end

endmodule

// File: tb/tb_axil_timer.sv
// Directed bench for axil_timer: register-level reference model plus literal expectations.
`timescale 1ns/1ps
module tb_axil_timer;
  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, irq_o;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  axil_timer #(.ADDR_WIDTH(8), .CNT_RESET(64'h0)) dut (
    .clk(clk), .nrst(nrst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .irq_o(irq_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: software-visible registers, stepped once per clock.
  logic [2:0]  m_ctrl;
  logic        m_match, m_irq;
  logic [63:0] m_cnt, m_cmp;
  logic [31:0] m_shadow;
  logic        mw_go = 0, mr_go = 0;
  logic [31:0] mw_addr, mw_data, mr_addr;
  logic [3:0]  mw_strb;

  function automatic logic [31:0] bytes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic        hit, irq_n, match_n, w1c;
  logic [63:0] cnt_n, cmp_n;
  logic [2:0]  ctrl_n;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_ctrl = '0; m_match = 0; m_irq = 0; m_cnt = 64'h0; m_cmp = '1; m_shadow = '0;
    end else begin
      hit     = m_ctrl[0] && (m_cnt == m_cmp);
      irq_n   = m_match && m_ctrl[1];
      w1c     = mw_go && mw_addr[7:2] == 6'd1 && mw_strb[0] && mw_data[0];
      match_n = hit || (m_match && !w1c);
      cnt_n   = !m_ctrl[0] ? m_cnt : ((hit && m_ctrl[2]) ? 64'd0 : m_cnt + 64'd1);
      ctrl_n  = m_ctrl;
      cmp_n   = m_cmp;
      if (mw_go) begin
        case (mw_addr[7:2])
          6'd0: if (mw_strb[0]) ctrl_n = mw_data[2:0];
          6'd2: cnt_n = {m_cnt[63:32], bytes(m_cnt[31:0], mw_data, mw_strb)};
          6'd3: cnt_n = {bytes(m_cnt[63:32], mw_data, mw_strb), m_cnt[31:0]};
          6'd4: cmp_n = {m_cmp[63:32], bytes(m_cmp[31:0], mw_data, mw_strb)};
          6'd5: cmp_n = {bytes(m_cmp[63:32], mw_data, mw_strb), m_cmp[31:0]};
          default: ;
        endcase
      end
      if (mr_go && mr_addr[7:2] == 6'd2) m_shadow = m_cnt[63:32];
      m_irq = irq_n; m_match = match_n; m_cnt = cnt_n; m_ctrl = ctrl_n; m_cmp = cmp_n;
    end
  end

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    case (a[7:2])
      6'd0: d = {29'h0, m_ctrl};
      6'd1: d = {31'h0, m_match};
      6'd2: d = m_cnt[31:0];
      6'd3: d = m_shadow;
      6'd4: d = m_cmp[31:0];
      6'd5: d = m_cmp[63:32];
      default: begin d = 32'h0; r = 2'b10; end
    endcase
  endtask

  always @(negedge clk) if (nrst && run_cmp) chk("irq_o", irq_o, m_irq);

  // Entered and left on a falling edge; aw_dly/w_dly are cycles before each valid rises.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int hold_b, input string nm);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int c = 0;
    logic [1:0] er;
    er = (a[7:2] <= 6'd5) ? 2'b00 : 2'b10;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && c >= aw_dly; awaddr = a;
      wvalid  = !w_done && c >= w_dly;   wdata = d; wstrb = s;
      if (aw_done) chk({nm, " awready while holding AW"}, awready, 0);
      if (w_done)  chk({nm, " wready while holding W"}, wready, 0);
      if (awvalid) chk({nm, " awready"}, awready, 1);
      if (wvalid)  chk({nm, " wready"}, wready, 1);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      if ((aw_done || aw_now) && (w_done || w_now)) begin
        mw_go = 1; mw_addr = a; mw_data = d; mw_strb = s;
      end
      @(negedge clk);
      mw_go = 0;
      aw_done |= aw_now; w_done |= w_now; c++;
      if (c > 40) begin
        chk({nm, " handshake timeout"}, {aw_done, w_done}, 2'b11);
        aw_done = 1; w_done = 1;
      end
    end
    awvalid = 0; wvalid = 0;
    chk({nm, " bvalid"}, bvalid, 1);
    chk({nm, " bresp"}, bresp, er);
    for (int k = 0; k < hold_b; k++) begin
      bready = 0;
      @(negedge clk);
      chk({nm, " bvalid held"}, bvalid, 1);
      chk({nm, " bresp held"}, bresp, er);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    chk({nm, " bvalid dropped"}, bvalid, 0);
    chk({nm, " ready again"}, {awready, wready}, 2'b11);
  endtask

  task automatic rd(input logic [31:0] a, input string nm,
                    output logic [31:0] got, output logic [1:0] gresp);
    logic [31:0] ed;
    logic [1:0]  er;
    m_read(a, ed, er);
    arvalid = 1; araddr = a;
    chk({nm, " arready"}, arready, 1);
    mr_go = 1; mr_addr = a;
    @(negedge clk);
    arvalid = 0; mr_go = 0;
    chk({nm, " rvalid"}, rvalid, 1);
    chk({nm, " arready busy"}, arready, 0);
    chk({nm, " rdata"}, rdata, ed);
    chk({nm, " rresp"}, rresp, er);
    got = rdata; gresp = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
    chk({nm, " rvalid dropped"}, rvalid, 0);
    chk({nm, " arready again"}, arready, 1);
  endtask

  logic [31:0] v, v2;
  logic [1:0]  rs, rs2;
  int n;

  initial begin
    nrst = 0; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    repeat (2) @(negedge clk);
    chk("rst awready", awready, 1);  chk("rst wready", wready, 1);
    chk("rst arready", arready, 1);  chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", rvalid, 0);    chk("rst bresp", bresp, 0);
    chk("rst rresp", rresp, 0);      chk("rst rdata", rdata, 0);
    chk("rst irq_o", irq_o, 0);
    nrst = 1; run_cmp = 1;

    wr(32'h10, 32'h64, 4'hF, 0, 3, 0, "cmp_lo aw first");
    rd(32'h10, "cmp_lo", v, rs);        chk("cmp_lo value", v, 32'h64);

    wr(32'h00, 32'h7, 4'hF, 2, 0, 0, "ctrl w first");
    wr(32'h00, 32'h7, 4'hF, 0, 0, 0, "ctrl same cycle");
    rd(32'h00, "ctrl", v, rs);          chk("ctrl value", v, 32'h7);

    wr(32'h00, 32'h0, 4'hF, 0, 0, 0, "ctrl off");
    wr(32'h04, 32'h1, 4'hF, 0, 0, 0, "status clr");
    wr(32'h08, 32'h0, 4'hF, 0, 0, 0, "cnt_lo");
    wr(32'h0C, 32'h0, 4'hF, 0, 0, 0, "cnt_hi");
    wr(32'h14, 32'h0, 4'hF, 0, 0, 0, "cmp_hi");
    wr(32'h10, 32'd10, 4'hF, 0, 0, 0, "cmp_lo 10");
    wr(32'h00, 32'h7, 4'hF, 0, 0, 0, "ctrl run");
    n = 0;
    while (irq_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("irq rise latency", n, 11);
    rd(32'h08, "cnt after match", v, rs); chk("cnt restarted", v, 32'd1);
    wr(32'h04, 32'h1, 4'hF, 0, 0, 0, "w1c match");
    chk("irq cleared", irq_o, 0);
    wr(32'h00, 32'h0, 4'hF, 0, 0, 0, "ctrl stop");
    rd(32'h04, "status", v, rs);        chk("status cleared", v, 32'h0);

    wr(32'h08, 32'hFFFF_FFFE, 4'hF, 0, 0, 0, "cnt_lo near wrap");
    wr(32'h0C, 32'h1, 4'hF, 0, 0, 0, "cnt_hi 1");
    wr(32'h00, 32'h1, 4'hF, 0, 0, 0, "ctrl en");
    rd(32'h08, "snap lo", v, rs);       chk("snap lo value", v, 32'hFFFF_FFFF);
    rd(32'h0C, "snap hi", v, rs);       chk("snap hi value", v, 32'h1);
    wr(32'h00, 32'h0, 4'hF, 0, 0, 0, "ctrl stop2");

    rd(32'h40, "unmapped rd", v, rs);
    chk("unmapped rdata", v, 32'h0);    chk("unmapped rresp", rs, 2'b10);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 5, "unmapped wr");
    rd(32'h00, "ctrl after unmapped", v, rs);

    wr(32'h14, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, "cmp_hi strobe");
    wr(32'h14, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, "cmp_hi no-op");
    rd(32'h14, "cmp_hi", v, rs);        chk("cmp_hi strobed", v, 32'h00BB_00DD);

    fork
      wr(32'h10, 32'h55, 4'hF, 0, 0, 0, "cmp_lo concurrent");
      rd(32'h10, "cmp_lo concurrent", v2, rs2);
    join
    chk("read before write", v2, 32'd10);
    rd(32'h10, "cmp_lo new", v, rs);    chk("cmp_lo after write", v, 32'h55);

    awvalid = 1; awaddr = 32'h14;
    chk("partial awready", awready, 1);
    @(negedge clk);
    awvalid = 0;
    chk("have_aw awready", awready, 0); chk("have_aw wready", wready, 1);
    nrst = 0;
    #1;
    chk("mid rst awready", awready, 1); chk("mid rst wready", wready, 1);
    chk("mid rst arready", arready, 1); chk("mid rst bvalid", bvalid, 0);
    chk("mid rst rvalid", rvalid, 0);   chk("mid rst irq_o", irq_o, 0);
    chk("mid rst rdata", rdata, 0);
    @(negedge clk);
    nrst = 1;
    rd(32'h14, "cmp_hi reset", v, rs);  chk("cmp_hi reset value", v, 32'hFFFF_FFFF);
    wr(32'h10, 32'h1234, 4'hF, 1, 0, 0, "post reset wr");
    rd(32'h10, "post reset rd", v, rs); chk("post reset value", v, 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
